// File: rtl/ram_sync_clr_pkg.sv
// Shared constants and state encoding for the clearable synchronous RAM.
// No logic; consumed by the controller and the top level.
// No flow control of its own.
package ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_sync_clr_if.sv
// Client-side bus of the clearable RAM: access request, read return, busy flag.
// Read data returns one cycle after the request edge.
// Accesses presented while busy is high are silently dropped.
interface ram_sync_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYTE_WIDTH = 8
);
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  ena;
    logic                  wena;
    logic [NBYTES-1:0]     be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  clr_req;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output ena, wena, be, addr, data_in, clr_req,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  ena, wena, be, addr, data_in, clr_req,
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/ram_sync_clr_clear_ctrl.sv
// Clear sequencer: owns the array after reset or a clear request and sweeps every word.
// Sweep takes DEPTH edges; busy is a registered state decode.
// Clear requests arriving mid-sweep are ignored rather than restarting it.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_ptr;

    // Sweep FSM: walk clr_ptr through every word, then hand the array back to the client.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= IDLE;
                        clr_ptr <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    assign sweep_we   = (state == CLEAR);
    assign sweep_addr = clr_ptr;

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with byte-lane writes, registered read and a hardware clear sweep.
// Read latency 1 cycle; rd_valid marks read returns only.
// No backpressure: client accesses during the sweep (busy=1) are dropped.
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 5,
    parameter int                   BYTE_WIDTH = 8,
    parameter int                   READ_MODE  = READ_FIRST,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_sync_clr_if.slave      bus
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ram_sync_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  busy;
    logic                  idle;
    logic                  cli_wr;
    logic                  cli_rd;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;

    ram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (bus.clr_req),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    assign idle     = ~sweep_we;
    assign cli_wr   = idle & bus.ena & bus.wena;
    assign cli_rd   = idle & bus.ena & ~bus.wena;
    assign old_word = mem[bus.addr];

    // Byte-lane merge of the client write over the current word, for write-first returns.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (bus.be[i]) begin
                merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Array write port: the sweep has priority; otherwise enabled client lanes update the word.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= INIT_VALUE;
        end else if (cli_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.be[i]) begin
                    mem[bus.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Output registers: reads and writes both refresh data_out, only reads raise rd_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= cli_rd;
            if (cli_rd) begin
                data_out_q <= old_word;
            end else if (cli_wr) begin
                data_out_q <= (READ_MODE == WRITE_FIRST) ? merged_word : old_word;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy;

endmodule

// File: doc/ram_sync_clr.md
# ram_sync_clr

Parametrised single-port synchronous RAM that succeeds the fixed 32×32 `ram` block. It adds configurable width and depth, per-byte write enables, a registered read with a valid strobe, and a selectable read-during-write mode. It also has a hardware clear engine that sweeps every word to a programmable value after reset or on request. It sits between the datapath and any client that needs scratch storage with a known initial state.

## Interface
- `DATA_WIDTH`, default 32: word width in bits; must be a multiple of `BYTE_WIDTH`.
- `ADDR_WIDTH`, default 5: address width; depth is `DEPTH = 2**ADDR_WIDTH` words.
- `BYTE_WIDTH`, default 8: bits per write-enable lane; `NBYTES = DATA_WIDTH/BYTE_WIDTH`.
- `READ_MODE`, default 0: 0 = read-first (old data on write), 1 = write-first (merged new data on write).
- `INIT_VALUE`, default 0: `DATA_WIDTH`-bit value written to every word by the clear engine.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: access enable.
- `wena` in 1: 1 = write, 0 = read; qualified by `ena`.
- `be` in `NBYTES`: byte-lane write enables; used only when writing.
- `addr` in `ADDR_WIDTH`: word address.
- `data_in` in `DATA_WIDTH`: write data.
- `clr_req` in 1: pulse that requests a full clear sweep.
- `data_out` out `DATA_WIDTH`: registered read data.
- `rd_valid` out 1: high for one cycle when `data_out` carries fresh read data.
- `busy` out 1: high while the clear engine owns the array.

## Operation
- Two-state FSM in package enum: `CLEAR`, `IDLE`. A pointer `clr_ptr` of `ADDR_WIDTH` bits tracks the sweep.
- Reset (asynchronous, `rst_n`=0) sets:
  - state=`CLEAR`, `clr_ptr`=0;
  - `data_out`=0, `rd_valid`=0, `busy`=1.
  - The array contents are not reset directly; only the sweep initialises them.
- `CLEAR` state:
  - each edge writes `INIT_VALUE` to `mem[clr_ptr]` on all lanes, then increments `clr_ptr`;
  - at `clr_ptr`=`DEPTH-1`, the last word is written, the pointer wraps to 0 and state goes to `IDLE`;
  - `ena`, `wena`, `be` and `clr_req` are ignored; `rd_valid` stays 0 and `data_out` holds its value.
- `IDLE` state, `ena`=1, `wena`=1:
  - for each lane i with `be[i]`=1, that byte slice of `mem[addr]` takes `data_in`;
  - `be`=0 makes the write a no-op on the array.
- `IDLE` state, `ena`=1, `wena`=0: `data_out`←`mem[addr]`.
- `IDLE` state, write cycle, `data_out` update:
  - `READ_MODE`=0 loads the pre-write word;
  - `READ_MODE`=1 loads the byte-merged post-write word.
- `rd_valid`:
  - registered copy of (`IDLE` & `ena` & ~`wena`);
  - it does not assert for write cycles, even though `data_out` updates on them.
- `ena`=0: array untouched, `data_out` holds, `rd_valid`=0.
- `clr_req` in `IDLE`:
  - enters `CLEAR` at the next edge with `clr_ptr`=0;
  - an access presented in the same cycle is still performed.
- `clr_req` in `CLEAR` is ignored; the sweep is not restarted.
- Reset asserted mid-sweep restarts the sweep from address 0.

## Timing
- Read latency is 1 cycle: address at edge N, then `data_out` and `rd_valid` are valid after edge N.
- Back-to-back reads every cycle are supported, with `rd_valid` held high continuously.
- Write to address A at edge N, then read of A at edge N+1, returns the new data.
- The clear sweep takes exactly `DEPTH` edges after `rst_n` rises; `busy` falls after edge `DEPTH-1`.
  - Default configuration: 32 edges.
- After `clr_req` is sampled at edge N, `busy` goes high after edge N and low after edge N+`DEPTH`.
- `busy` is a registered state decode with no combinational path from inputs.

## Structure
- Package `ram_pkg` holds:
  - `READ_FIRST`=0 and `WRITE_FIRST`=1 constants;
  - the state enum {`CLEAR`, `IDLE`}.
- One sub-module, `ram_clear_ctrl`: contains the FSM, `clr_ptr` and `busy`, and outputs the sweep write enable and address.
- The top level contains the array, the byte-lane write loop, the address/data muxing between client and sweep, and the output registers.
- Parameter check: elaboration fails if `DATA_WIDTH % BYTE_WIDTH` ≠ 0.

## Test plan
- Reset release with defaults and `INIT_VALUE`=32'hDEAD_BEEF → `busy`=1 for 32 edges, then reads of addresses 0..31 all return 32'hDEAD_BEEF, with `rd_valid`=1 one cycle after each read.
- Writes of `data_in`=addr+1 to addresses 0..30 with `be`=4'hF, then reads 0..30 → `data_out`=1..31 in order, 1-cycle latency.
- Address 5 holding 32'h1122_3344; write 32'hAABB_CCDD with `be`=4'b0101 → the next read of address 5 returns 32'h11BB_33DD.
- `READ_MODE`=0 versus `READ_MODE`=1, writing 32'h0000_00FF over 32'h1234_5678 → `data_out` after the write edge is 32'h1234_5678 (read-first) versus 32'h0000_00FF (write-first); `rd_valid`=0 in both modes.
- `clr_req` pulse together with a write of 32'h5555_5555 to address 3 → the write lands, `busy` stays high for 32 cycles, accesses during the sweep are ignored, and address 3 then reads `INIT_VALUE`.
- `rst_n` pulsed low at sweep address 10 → `busy` stays high for a full 32 further edges, and all words read `INIT_VALUE` afterwards.
